// File: rtl/imm_extend_pipe.sv
// Immediate-field extender (SEXT / ZEXT / SEXT_SHL / SEXT_NEG) feeding a
// 2-entry ready/valid output FIFO, with a wrapping output-handshake counter.
module imm_extend_pipe #(
  parameter int IN_W  = 10,
  parameter int OUT_W = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [1:0]       in_mode,
  input  logic [1:0]       in_shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_neg,
  output logic [CNT_W-1:0] xfer_cnt
);

  if (IN_W < 2) begin : g_bad_in_w
    $error("imm_extend_pipe: IN_W must be >= 2");
  end
  if (OUT_W <= IN_W) begin : g_bad_out_w
    $error("imm_extend_pipe: OUT_W must be greater than IN_W");
  end

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_t;

  typedef enum logic [1:0] {
    MODE_SEXT     = 2'b00,
    MODE_ZEXT     = 2'b01,
    MODE_SEXT_SHL = 2'b10,
    MODE_SEXT_NEG = 2'b11
  } mode_t;

  occ_t state_q, state_d;

  logic [OUT_W-1:0] sext, zext, res;
  logic [OUT_W-1:0] head_data, tail_data;
  logic             head_neg, tail_neg;
  logic             push, pop;
  logic             head_we, head_from_tail, tail_we;

  assign sext = {{(OUT_W-IN_W){in_data[IN_W-1]}}, in_data};
  assign zext = {{(OUT_W-IN_W){1'b0}}, in_data};

  always_comb begin
    res = sext;
    unique case (mode_t'(in_mode))
      MODE_SEXT:     res = sext;
      MODE_ZEXT:     res = zext;
      MODE_SEXT_SHL: res = sext << in_shamt;
      MODE_SEXT_NEG: res = -sext;
      default:       res = sext;
    endcase
  end

  assign in_ready  = rst_n && (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign out_data  = head_data;
  assign out_neg   = head_neg;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Head always holds the oldest entry; a simultaneous push/pop with one
  // entry overwrites the head directly instead of going through the tail.
  always_comb begin
    state_d        = state_q;
    head_we        = 1'b0;
    head_from_tail = 1'b0;
    tail_we        = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (push) begin
          state_d = ONE;
          head_we = 1'b1;
        end
      end
      ONE: begin
        if (push && pop) begin
          head_we = 1'b1;
        end else if (push) begin
          state_d = FULL;
          tail_we = 1'b1;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          state_d        = ONE;
          head_we        = 1'b1;
          head_from_tail = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= EMPTY;
      head_data <= '0;
      head_neg  <= 1'b0;
      tail_data <= '0;
      tail_neg  <= 1'b0;
      xfer_cnt  <= '0;
    end else begin
      state_q <= state_d;
      if (head_we) begin
        head_data <= head_from_tail ? tail_data : res;
        head_neg  <= head_from_tail ? tail_neg : res[OUT_W-1];
      end
      if (tail_we) begin
        tail_data <= res;
        tail_neg  <= res[OUT_W-1];
      end
      if (pop) begin
        xfer_cnt <= xfer_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Bench for imm_extend_pipe: directed and random stimulus against a queue-based
// reference model; a second instance with a 4-bit counter checks wrap-around.
module tb_imm_extend_pipe;

  localparam int IN_W  = 10;
  localparam int OUT_W = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic [IN_W-1:0]  in_data;
  logic [1:0]       in_mode;
  logic [1:0]       in_shamt;
  logic             out_ready;

  logic             in_ready, out_valid, out_neg;
  logic [OUT_W-1:0] out_data;
  logic [15:0]      xfer_cnt;

  logic             in_ready4, out_valid4, out_neg4;
  logic [OUT_W-1:0] out_data4;
  logic [3:0]       xfer_cnt4;

  always #5 clk = ~clk;

  imm_extend_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_mode(in_mode), .in_shamt(in_shamt),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_neg(out_neg), .xfer_cnt(xfer_cnt)
  );

  imm_extend_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
    .in_data(in_data), .in_mode(in_mode), .in_shamt(in_shamt),
    .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
    .out_neg(out_neg4), .xfer_cnt(xfer_cnt4)
  );

  typedef struct {
    logic [IN_W-1:0] d;
    logic [1:0]      m;
    logic [1:0]      s;
  } item_t;

  int unsigned      total = 0;
  int unsigned      bad   = 0;
  logic [OUT_W-1:0] q[$];
  int unsigned      cnt = 0;
  bit               last_push;
  item_t            pending[$];
  int unsigned      base;

  // Reference: interpret the field as an integer, then apply plain arithmetic.
  function automatic logic [OUT_W-1:0] ref_calc(logic [IN_W-1:0] d, logic [1:0] m, logic [1:0] s);
    longint v;
    v = (d >= (1 << (IN_W-1))) ? longint'(d) - (longint'(1) << IN_W) : longint'(d);
    case (m)
      2'd1:    v = longint'(d);
      2'd2:    v = v * (longint'(1) << s);
      2'd3:    v = -v;
      default: ;
    endcase
    return v[OUT_W-1:0];
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: check every output against the model at the falling edge,
  // then advance the model on the rising edge.
  task automatic cyc();
    bit rdy, vld, p, o;
    @(negedge clk);
    rdy = rst_n && (q.size() < 2);
    vld = (q.size() > 0);
    chk("in_ready", in_ready, rdy);
    chk("out_valid", out_valid, vld);
    chk("xfer_cnt", xfer_cnt, cnt % 65536);
    chk("in_ready4", in_ready4, rdy);
    chk("out_valid4", out_valid4, vld);
    chk("xfer_cnt4", xfer_cnt4, cnt % 16);
    if (vld) begin
      chk("out_data", out_data, q[0]);
      chk("out_neg", out_neg, q[0][OUT_W-1]);
      chk("out_data4", out_data4, q[0]);
    end
    @(posedge clk);
    p = 1'b0;
    if (!rst_n) begin
      q.delete();
      cnt = 0;
    end else begin
      p = in_valid && (q.size() < 2);
      o = out_ready && (q.size() > 0);
      if (o) begin
        void'(q.pop_front());
        cnt++;
      end
      if (p) q.push_back(ref_calc(in_data, in_mode, in_shamt));
    end
    last_push = p;
    #1;
  endtask

  task automatic run_feed(int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      in_valid = (pending.size() > 0);
      if (pending.size() > 0) begin
        in_data  = pending[0].d;
        in_mode  = pending[0].m;
        in_shamt = pending[0].s;
      end
      cyc();
      if (last_push) void'(pending.pop_front());
    end
    in_valid = 1'b0;
  endtask

  task automatic push_one(string tag, logic [IN_W-1:0] d, logic [1:0] m, logic [1:0] s,
                          logic [OUT_W-1:0] exp);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = d;
    in_mode   = m;
    in_shamt  = s;
    cyc();
    in_valid = 1'b0;
    chk({tag, "_valid"}, out_valid, 1'b1);
    chk({tag, "_data"}, out_data, exp);
    chk({tag, "_neg"}, out_neg, exp[OUT_W-1]);
    cyc();
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b1; in_data = 10'h155; in_mode = 2'b00;
    in_shamt = 2'd0; out_ready = 1'b1;
    cyc(); cyc();
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_out_neg", out_neg, 1'b0);
    in_valid = 1'b0;
    rst_n = 1'b1;

    push_one("sext_min",  10'h200, 2'b00, 2'd3, 32'hFFFFFE00);
    push_one("sext_max",  10'h1FF, 2'b00, 2'd1, 32'h000001FF);
    push_one("zext",      10'h3FF, 2'b01, 2'd2, 32'h000003FF);
    push_one("shl2",      10'h3FF, 2'b10, 2'd2, 32'hFFFFFFFC);
    push_one("shl3",      10'h001, 2'b10, 2'd3, 32'h00000008);
    push_one("neg_min",   10'h200, 2'b11, 2'd1, 32'h00000200);
    push_one("neg_one",   10'h001, 2'b11, 2'd0, 32'hFFFFFFFF);
    push_one("neg_zero",  10'h000, 2'b11, 2'd2, 32'h00000000);

    // Backpressure: A, B fill the buffer, C is held off until a pop.
    base = cnt;
    out_ready = 1'b0;
    pending.push_back('{10'h001, 2'b00, 2'd0});
    pending.push_back('{10'h002, 2'b00, 2'd0});
    pending.push_back('{10'h003, 2'b00, 2'd0});
    run_feed(4);
    chk("bp_in_ready_low", in_ready, 1'b0);
    chk("bp_c_pending", pending.size(), 1);
    out_ready = 1'b1;
    run_feed(5);
    chk("bp_xfer3", xfer_cnt, (base + 3) % 65536);

    // Steady state with one entry: push and pop every cycle.
    out_ready = 1'b0;
    pending.push_back('{10'h0AA, 2'b01, 2'd0});
    run_feed(1);
    out_ready = 1'b1;
    base = cnt;
    for (int unsigned i = 0; i < 10; i++)
      pending.push_back('{IN_W'($urandom), 2'($urandom), 2'($urandom)});
    for (int unsigned i = 0; i < 10; i++) begin
      run_feed(1);
      chk("ss_in_ready", in_ready, 1'b1);
      chk("ss_out_valid", out_valid, 1'b1);
    end
    chk("ss_xfer10", xfer_cnt, (base + 10) % 65536);
    run_feed(1);

    // Reset from FULL, then 17 pops on the 4-bit counter instance.
    out_ready = 1'b0;
    pending.push_back('{10'h011, 2'b00, 2'd0});
    pending.push_back('{10'h022, 2'b00, 2'd0});
    run_feed(2);
    chk("full_in_ready", in_ready, 1'b0);
    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    cyc();
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_xfer", xfer_cnt, 16'h0);
    rst_n = 1'b1; in_valid = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1'b1);
    push_one("post_rst", 10'h3F0, 2'b00, 2'd0, 32'hFFFFFFF0);
    for (int unsigned i = 0; i < 16; i++)
      pending.push_back('{IN_W'($urandom), 2'($urandom), 2'($urandom)});
    run_feed(18);
    chk("wrap_cnt4", xfer_cnt4, 4'd1);
    chk("wrap_cnt16", xfer_cnt, 16'd17);

    // Random traffic with occasional resets.
    for (int unsigned i = 0; i < 600; i++) begin
      rst_n     = ($urandom_range(63) != 0);
      in_valid  = $urandom_range(1);
      out_ready = ($urandom_range(3) != 0);
      in_data   = IN_W'($urandom);
      in_mode   = 2'($urandom);
      in_shamt  = 2'($urandom);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
